// File: rtl/rat.sv
// ---------------------------------------------------------------------------
// rat -- register alias table for a dual-slot (int + ls) renaming stage.
//
// Keeps a 32-entry architectural-to-physical map and a circular free list of
// physical tags. Each accepted pair is renamed in one cycle. The results are
// registered toward the issuer (ii) and toward the ROB (rob).
//
// Ports
//   clk, res                    clock, synchronous active-high reset
//   valid/rsrc/rd_int_id2rat    int-slot instruction from ID
//   valid/rsrc/rd_ls_id2rat     ls-slot instruction from ID (rd=0 for stores)
//   stall_rat2id                combinational: the pair is not accepted
//   valid_rat2ii, psrc/prd_*    renamed pair toward the issuer
//   full_rob2rat                the ROB cannot take a pair
//   freeMeUp_*_rat2rob          previous mappings of the renamed destinations
//   done_rat2rob                one-cycle pulse per accepted pair
//   freeMeUp_0/1_rob2rat        tags released by commit, qualified by
//   valid_rob2rat
//
// Optional feature: define RAT_FREE_BYPASS_EN so that tags released by commit
// can be allocated in the same cycle they arrive.
// ---------------------------------------------------------------------------
module rat #(
    parameter int PTAGW = 6
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 valid_int_id2rat,
    input  logic [9:0]           rsrc_int_id2rat,
    input  logic [4:0]           rd_int_id2rat,
    input  logic                 valid_ls_id2rat,
    input  logic [9:0]           rsrc_ls_id2rat,
    input  logic [4:0]           rd_ls_id2rat,
    output logic                 stall_rat2id,
    output logic                 valid_rat2ii,
    output logic [2*PTAGW-1:0]   psrc_int_rat2ii,
    output logic [PTAGW-1:0]     prd_int_rat2ii,
    output logic [2*PTAGW-1:0]   psrc_ls_rat2ii,
    output logic [PTAGW-1:0]     prd_ls_rat2ii,
    input  logic                 full_rob2rat,
    output logic [PTAGW-1:0]     freeMeUp_int_rat2rob,
    output logic [PTAGW-1:0]     freeMeUp_ls_rat2rob,
    output logic                 done_rat2rob,
    input  logic [PTAGW-1:0]     freeMeUp_0_rob2rat,
    input  logic [PTAGW-1:0]     freeMeUp_1_rob2rat,
    input  logic                 valid_rob2rat
);

    localparam int NPHYS = 2 ** PTAGW;
    localparam int NARCH = 32;
    localparam int CNTW  = PTAGW + 1;

    logic [PTAGW-1:0] map_r [NARCH];
    logic [PTAGW-1:0] fl_r  [NPHYS];
    logic [PTAGW-1:0] head_r;
    logic [PTAGW-1:0] tail_r;
    logic [CNTW-1:0]  count_r;

    logic             push0_s;
    logic             push1_s;
    logic [1:0]       npush_s;
    logic [PTAGW-1:0] pushv0_s;
    logic [PTAGW-1:0] pushv1_s;
    logic             need_int_s;
    logic             need_ls_s;
    logic [1:0]       need_s;
    logic [CNTW:0]    avail_s;
    logic             any_s;
    logic             stall_s;
    logic             accept_s;
    logic             alloc_int_s;
    logic             alloc_ls_s;
    logic [1:0]       npop_s;
    logic [PTAGW-1:0] head_p1_s;
    logic [PTAGW-1:0] tail_p1_s;
    logic [PTAGW-1:0] cand0_s;
    logic [PTAGW-1:0] cand1_s;
    logic [PTAGW-1:0] prd_int_s;
    logic [PTAGW-1:0] prd_ls_s;
    logic [PTAGW-1:0] src_int1_s;
    logic [PTAGW-1:0] src_int2_s;
    logic [PTAGW-1:0] src_ls1_s;
    logic [PTAGW-1:0] src_ls2_s;
    logic [PTAGW-1:0] free_int_s;
    logic [PTAGW-1:0] free_ls_s;

    // Commit-side frees: zero tags are dropped, survivors are packed in order.
    always_comb begin
        push0_s  = valid_rob2rat && (freeMeUp_0_rob2rat != {PTAGW{1'b0}});
        push1_s  = valid_rob2rat && (freeMeUp_1_rob2rat != {PTAGW{1'b0}});
        npush_s  = {1'b0, push0_s} + {1'b0, push1_s};
        pushv0_s = push0_s ? freeMeUp_0_rob2rat : freeMeUp_1_rob2rat;
        pushv1_s = freeMeUp_1_rob2rat;
    end

    // Allocation demand, availability and the accept/stall decision.
    always_comb begin
        need_int_s = valid_int_id2rat && (rd_int_id2rat != 5'd0);
        need_ls_s  = valid_ls_id2rat  && (rd_ls_id2rat  != 5'd0);
        need_s     = {1'b0, need_int_s} + {1'b0, need_ls_s};
`ifdef RAT_FREE_BYPASS_EN
        avail_s    = {1'b0, count_r} + (CNTW+1)'(npush_s);
`else
        avail_s    = {1'b0, count_r};
`endif
        any_s       = valid_int_id2rat || valid_ls_id2rat;
        stall_s     = any_s && (full_rob2rat || (avail_s < (CNTW+1)'(need_s)));
        accept_s    = any_s && !stall_s;
        alloc_int_s = accept_s && need_int_s;
        alloc_ls_s  = accept_s && need_ls_s;
        npop_s      = {1'b0, alloc_int_s} + {1'b0, alloc_ls_s};
    end

    // The first two tags the free list would hand out this cycle. With the
    // bypass, a short list is topped up by this cycle's frees.
    always_comb begin
        head_p1_s = head_r + PTAGW'(1);
        tail_p1_s = tail_r + PTAGW'(1);
`ifdef RAT_FREE_BYPASS_EN
        if (count_r == CNTW'(0)) begin
            cand0_s = pushv0_s;
            cand1_s = pushv1_s;
        end else if (count_r == CNTW'(1)) begin
            cand0_s = fl_r[head_r];
            cand1_s = pushv0_s;
        end else begin
            cand0_s = fl_r[head_r];
            cand1_s = fl_r[head_p1_s];
        end
`else
        cand0_s = fl_r[head_r];
        cand1_s = fl_r[head_p1_s];
`endif
    end

    // Rename: int pops first; ls sees int's new mapping for shared registers.
    always_comb begin
        prd_int_s = alloc_int_s ? cand0_s : {PTAGW{1'b0}};
        if (alloc_ls_s) begin
            prd_ls_s = alloc_int_s ? cand1_s : cand0_s;
        end else begin
            prd_ls_s = {PTAGW{1'b0}};
        end
        src_int1_s = map_r[rsrc_int_id2rat[4:0]];
        src_int2_s = map_r[rsrc_int_id2rat[9:5]];
        src_ls1_s  = (alloc_int_s && (rsrc_ls_id2rat[4:0] == rd_int_id2rat))
                   ? prd_int_s : map_r[rsrc_ls_id2rat[4:0]];
        src_ls2_s  = (alloc_int_s && (rsrc_ls_id2rat[9:5] == rd_int_id2rat))
                   ? prd_int_s : map_r[rsrc_ls_id2rat[9:5]];
        free_int_s = alloc_int_s ? map_r[rd_int_id2rat] : {PTAGW{1'b0}};
        if (alloc_ls_s) begin
            free_ls_s = (alloc_int_s && (rd_ls_id2rat == rd_int_id2rat))
                      ? prd_int_s : map_r[rd_ls_id2rat];
        end else begin
            free_ls_s = {PTAGW{1'b0}};
        end
    end

    assign stall_rat2id = stall_s;

    // Map table: identity on reset, ls write wins over int for the same rd.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < NARCH; i++) begin
                map_r[i] <= PTAGW'(i);
            end
        end else begin
            if (alloc_int_s) begin
                map_r[rd_int_id2rat] <= prd_int_s;
            end
            if (alloc_ls_s) begin
                map_r[rd_ls_id2rat] <= prd_ls_s;
            end
        end
    end

    // Free list storage and pointers; pushes and pops may share a cycle.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < NPHYS; i++) begin
                fl_r[i] <= (i < NPHYS - NARCH) ? PTAGW'(i + NARCH) : {PTAGW{1'b0}};
            end
            head_r  <= {PTAGW{1'b0}};
            tail_r  <= PTAGW'(NPHYS - NARCH);
            count_r <= CNTW'(NPHYS - NARCH);
        end else begin
            if (npush_s != 2'd0) begin
                fl_r[tail_r] <= pushv0_s;
            end
            if (npush_s == 2'd2) begin
                fl_r[tail_p1_s] <= pushv1_s;
            end
            tail_r  <= tail_r + PTAGW'(npush_s);
            head_r  <= head_r + PTAGW'(npop_s);
            count_r <= count_r + CNTW'(npush_s) - CNTW'(npop_s);
        end
    end

    // Registered results toward issuer and ROB; data holds between accepts.
    always_ff @(posedge clk) begin
        if (res) begin
            valid_rat2ii         <= 1'b0;
            done_rat2rob         <= 1'b0;
            psrc_int_rat2ii      <= {(2*PTAGW){1'b0}};
            prd_int_rat2ii       <= {PTAGW{1'b0}};
            psrc_ls_rat2ii       <= {(2*PTAGW){1'b0}};
            prd_ls_rat2ii        <= {PTAGW{1'b0}};
            freeMeUp_int_rat2rob <= {PTAGW{1'b0}};
            freeMeUp_ls_rat2rob  <= {PTAGW{1'b0}};
        end else if (accept_s) begin
            valid_rat2ii         <= 1'b1;
            done_rat2rob         <= 1'b1;
            psrc_int_rat2ii      <= {src_int2_s, src_int1_s};
            prd_int_rat2ii       <= prd_int_s;
            psrc_ls_rat2ii       <= {src_ls2_s, src_ls1_s};
            prd_ls_rat2ii        <= prd_ls_s;
            freeMeUp_int_rat2rob <= free_int_s;
            freeMeUp_ls_rat2rob  <= free_ls_s;
        end else begin
            valid_rat2ii <= 1'b0;
            done_rat2rob <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rat.sv
// ---------------------------------------------------------------------------
// tb_rat -- self-checking bench for rat (PTAGW = 6).
// A queue/array model of the rename rules runs on every rising edge. A compare
// process checks all DUT outputs against it on every falling edge. Directed
// scenarios add literal expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_rat;

    logic        clk;
    logic        res;
    logic        valid_int_id2rat;
    logic [9:0]  rsrc_int_id2rat;
    logic [4:0]  rd_int_id2rat;
    logic        valid_ls_id2rat;
    logic [9:0]  rsrc_ls_id2rat;
    logic [4:0]  rd_ls_id2rat;
    logic        stall_rat2id;
    logic        valid_rat2ii;
    logic [11:0] psrc_int_rat2ii;
    logic [5:0]  prd_int_rat2ii;
    logic [11:0] psrc_ls_rat2ii;
    logic [5:0]  prd_ls_rat2ii;
    logic        full_rob2rat;
    logic [5:0]  freeMeUp_int_rat2rob;
    logic [5:0]  freeMeUp_ls_rat2rob;
    logic        done_rat2rob;
    logic [5:0]  freeMeUp_0_rob2rat;
    logic [5:0]  freeMeUp_1_rob2rat;
    logic        valid_rob2rat;

    rat #(.PTAGW(6)) dut (
        .clk                  (clk),
        .res                  (res),
        .valid_int_id2rat     (valid_int_id2rat),
        .rsrc_int_id2rat      (rsrc_int_id2rat),
        .rd_int_id2rat        (rd_int_id2rat),
        .valid_ls_id2rat      (valid_ls_id2rat),
        .rsrc_ls_id2rat       (rsrc_ls_id2rat),
        .rd_ls_id2rat         (rd_ls_id2rat),
        .stall_rat2id         (stall_rat2id),
        .valid_rat2ii         (valid_rat2ii),
        .psrc_int_rat2ii      (psrc_int_rat2ii),
        .prd_int_rat2ii       (prd_int_rat2ii),
        .psrc_ls_rat2ii       (psrc_ls_rat2ii),
        .prd_ls_rat2ii        (prd_ls_rat2ii),
        .full_rob2rat         (full_rob2rat),
        .freeMeUp_int_rat2rob (freeMeUp_int_rat2rob),
        .freeMeUp_ls_rat2rob  (freeMeUp_ls_rat2rob),
        .done_rat2rob         (done_rat2rob),
        .freeMeUp_0_rob2rat   (freeMeUp_0_rob2rat),
        .freeMeUp_1_rob2rat   (freeMeUp_1_rob2rat),
        .valid_rob2rat        (valid_rob2rat)
    );

    int total = 0;
    int bad   = 0;

    // model state
    bit         live = 1'b0;
    logic [5:0] mp [32];
    logic [5:0] fq [$];
    logic       e_valid, e_done;
    logic [11:0] e_psi, e_psl;
    logic [5:0] e_pri, e_prl, e_fi, e_fl;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        int need;
        int avail;
        need  = int'(valid_int_id2rat && rd_int_id2rat != 5'd0)
              + int'(valid_ls_id2rat && rd_ls_id2rat != 5'd0);
        avail = fq.size();
`ifdef RAT_FREE_BYPASS_EN
        if (valid_rob2rat) begin
            avail += int'(freeMeUp_0_rob2rat != 6'd0) + int'(freeMeUp_1_rob2rat != 6'd0);
        end
`endif
        return (valid_int_id2rat || valid_ls_id2rat) && (full_rob2rat || avail < need);
    endfunction

    // behavioural model: sequential rename semantics on queues and arrays
    initial forever begin
        logic [5:0] fr [$];
        bit acc;
        @(posedge clk);
        if (res) begin
            live = 1'b1;
            fq.delete();
            for (int i = 0; i < 32; i++) begin
                mp[i] = 6'(i);
                fq.push_back(6'(i + 32));
            end
            e_valid = 1'b0; e_done = 1'b0;
            e_psi = 12'd0; e_psl = 12'd0;
            e_pri = 6'd0; e_prl = 6'd0; e_fi = 6'd0; e_fl = 6'd0;
        end else if (live) begin
            fr.delete();
            if (valid_rob2rat && freeMeUp_0_rob2rat != 6'd0) fr.push_back(freeMeUp_0_rob2rat);
            if (valid_rob2rat && freeMeUp_1_rob2rat != 6'd0) fr.push_back(freeMeUp_1_rob2rat);
            acc = (valid_int_id2rat || valid_ls_id2rat) && !m_stall();
`ifdef RAT_FREE_BYPASS_EN
            foreach (fr[k]) fq.push_back(fr[k]);
`endif
            if (acc) begin
                e_valid = 1'b1; e_done = 1'b1;
                e_psi = {mp[rsrc_int_id2rat[9:5]], mp[rsrc_int_id2rat[4:0]]};
                if (valid_int_id2rat && rd_int_id2rat != 5'd0) begin
                    e_pri = fq.pop_front();
                    e_fi  = mp[rd_int_id2rat];
                    mp[rd_int_id2rat] = e_pri;
                end else begin
                    e_pri = 6'd0; e_fi = 6'd0;
                end
                // ls reads the map as updated by int: this is the intra-pair bypass
                e_psl = {mp[rsrc_ls_id2rat[9:5]], mp[rsrc_ls_id2rat[4:0]]};
                if (valid_ls_id2rat && rd_ls_id2rat != 5'd0) begin
                    e_prl = fq.pop_front();
                    e_fl  = mp[rd_ls_id2rat];
                    mp[rd_ls_id2rat] = e_prl;
                end else begin
                    e_prl = 6'd0; e_fl = 6'd0;
                end
            end else begin
                e_valid = 1'b0; e_done = 1'b0;
            end
`ifndef RAT_FREE_BYPASS_EN
            foreach (fr[k]) fq.push_back(fr[k]);
`endif
        end
    end

    // compare process: every falling edge once the model is live
    initial forever begin
        @(negedge clk);
        if (live) begin
            chk("stall", 32'(stall_rat2id), 32'(m_stall()));
            chk("valid", 32'(valid_rat2ii), 32'(e_valid));
            chk("done", 32'(done_rat2rob), 32'(e_done));
            chk("psrc_int", 32'(psrc_int_rat2ii), 32'(e_psi));
            chk("prd_int", 32'(prd_int_rat2ii), 32'(e_pri));
            chk("psrc_ls", 32'(psrc_ls_rat2ii), 32'(e_psl));
            chk("prd_ls", 32'(prd_ls_rat2ii), 32'(e_prl));
            chk("free_int", 32'(freeMeUp_int_rat2rob), 32'(e_fi));
            chk("free_ls", 32'(freeMeUp_ls_rat2rob), 32'(e_fl));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_int_id2rat = 1'b0; rsrc_int_id2rat = 10'd0; rd_int_id2rat = 5'd0;
        valid_ls_id2rat  = 1'b0; rsrc_ls_id2rat  = 10'd0; rd_ls_id2rat  = 5'd0;
        full_rob2rat = 1'b0; valid_rob2rat = 1'b0;
        freeMeUp_0_rob2rat = 6'd0; freeMeUp_1_rob2rat = 6'd0;
    endtask

    task automatic pair(input logic vi, input logic [4:0] s2i, input logic [4:0] s1i,
                        input logic [4:0] di, input logic vl, input logic [4:0] s2l,
                        input logic [4:0] s1l, input logic [4:0] dl);
        valid_int_id2rat = vi; rsrc_int_id2rat = {s2i, s1i}; rd_int_id2rat = di;
        valid_ls_id2rat  = vl; rsrc_ls_id2rat  = {s2l, s1l}; rd_ls_id2rat  = dl;
    endtask

    task automatic do_reset();
        idle();
        res = 1'b1;
        cyc();
        res = 1'b0;
    endtask

    initial begin
        res = 1'b0;
        idle();
        cyc();
        cyc();

        // reset state
        do_reset();
        chk("rst_valid", 32'(valid_rat2ii), 32'd0);
        chk("rst_done", 32'(done_rat2rob), 32'd0);
        chk("rst_prd_int", 32'(prd_int_rat2ii), 32'd0);
        chk("rst_stall", 32'(stall_rat2id), 32'd0);

        // int rd=5, ls rd=6
        pair(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd6);
        #1 chk("t1_stall", 32'(stall_rat2id), 32'd0);
        cyc(); idle();
        chk("t1_prd_int", 32'(prd_int_rat2ii), 32'd32);
        chk("t1_prd_ls", 32'(prd_ls_rat2ii), 32'd33);
        chk("t1_free_int", 32'(freeMeUp_int_rat2rob), 32'd5);
        chk("t1_free_ls", 32'(freeMeUp_ls_rat2rob), 32'd6);
        chk("t1_done", 32'(done_rat2rob), 32'd1);
        cyc();
        chk("t1_done_pulse", 32'(done_rat2rob), 32'd0);
        chk("t1_prd_hold", 32'(prd_int_rat2ii), 32'd32);

        // same rd in both slots with ls reading it
        do_reset();
        pair(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 5'd0, 5'd3, 5'd3);
        cyc(); idle();
        chk("t2_ls_prs1", 32'(psrc_ls_rat2ii[5:0]), 32'd32);
        chk("t2_prd_int", 32'(prd_int_rat2ii), 32'd32);
        chk("t2_prd_ls", 32'(prd_ls_rat2ii), 32'd33);
        chk("t2_free_int", 32'(freeMeUp_int_rat2rob), 32'd3);
        chk("t2_free_ls", 32'(freeMeUp_ls_rat2rob), 32'd32);
        pair(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        cyc(); idle();
        chk("t2_map3", 32'(psrc_int_rat2ii[5:0]), 32'd33);
        chk("t2_rd0_prd", 32'(prd_int_rat2ii), 32'd0);
        // store (rd=0) in ls only, then int-only rename
        pair(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 5'd5, 5'd0);
        cyc(); idle();
        chk("t2_store_psrc", 32'(psrc_ls_rat2ii), {20'd0, 6'd33, 6'd5});
        chk("t2_store_prd", 32'(prd_ls_rat2ii), 32'd0);
        pair(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 5'd0, 5'd0, 5'd0);
        cyc(); idle();
        chk("t2_int_only_prd", 32'(prd_int_rat2ii), 32'd34);
        chk("t2_int_only_free", 32'(freeMeUp_int_rat2rob), 32'd7);

        // drain the free list with 16 dual renames
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pair(1'b1, 5'd0, 5'(i), 5'(i + 1), 1'b1, 5'(i + 1), 5'd0, 5'(i + 10));
            cyc();
        end
        chk("t3_last_prd_int", 32'(prd_int_rat2ii), 32'd62);
        chk("t3_last_prd_ls", 32'(prd_ls_rat2ii), 32'd63);
        pair(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 5'd0, 5'd0, 5'd8);
        #1 chk("t3_empty_stall", 32'(stall_rat2id), 32'd1);
        cyc();
        chk("t3_no_done", 32'(done_rat2rob), 32'd0);

        // count=0, commit frees 7 and 9 while the pair waits
        valid_rob2rat = 1'b1; freeMeUp_0_rob2rat = 6'd7; freeMeUp_1_rob2rat = 6'd9;
`ifdef RAT_FREE_BYPASS_EN
        #1 chk("t4_byp_stall", 32'(stall_rat2id), 32'd0);
        cyc(); idle();
`else
        #1 chk("t4_nobyp_stall", 32'(stall_rat2id), 32'd1);
        cyc();
        valid_rob2rat = 1'b0; freeMeUp_0_rob2rat = 6'd0; freeMeUp_1_rob2rat = 6'd0;
        #1 chk("t4_nobyp_stall2", 32'(stall_rat2id), 32'd0);
        chk("t4_nobyp_done0", 32'(done_rat2rob), 32'd0);
        cyc(); idle();
`endif
        chk("t4_done", 32'(done_rat2rob), 32'd1);
        chk("t4_prd_int", 32'(prd_int_rat2ii), 32'd7);
        chk("t4_prd_ls", 32'(prd_ls_rat2ii), 32'd9);
        // a zero free is ignored: only 12 enters the list
        valid_rob2rat = 1'b1; freeMeUp_0_rob2rat = 6'd0; freeMeUp_1_rob2rat = 6'd12;
        cyc(); idle();
        pair(1'b1, 5'd0, 5'd0, 5'd2, 1'b0, 5'd0, 5'd0, 5'd0);
        cyc(); idle();
        chk("t4_zero_skip", 32'(prd_int_rat2ii), 32'd12);

        // ROB full blocks without popping
        do_reset();
        full_rob2rat = 1'b1;
        pair(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd6);
        #1 chk("t5_full_stall", 32'(stall_rat2id), 32'd1);
        cyc();
        chk("t5_full_done", 32'(done_rat2rob), 32'd0);
        full_rob2rat = 1'b0;
        cyc();
        chk("t5_nopop_int", 32'(prd_int_rat2ii), 32'd32);
        chk("t5_nopop_ls", 32'(prd_ls_rat2ii), 32'd33);
        // reset mid-stream discards the pair and the frees
        valid_rob2rat = 1'b1; freeMeUp_0_rob2rat = 6'd34; freeMeUp_1_rob2rat = 6'd35;
        res = 1'b1;
        cyc();
        res = 1'b0; idle();
        chk("t5_rst_valid", 32'(valid_rat2ii), 32'd0);
        chk("t5_rst_prd", 32'(prd_int_rat2ii), 32'd0);
        pair(1'b1, 5'd6, 5'd5, 5'd7, 1'b0, 5'd0, 5'd0, 5'd0);
        cyc(); idle();
        chk("t5_map_ident", 32'(psrc_int_rat2ii), {20'd0, 6'd6, 6'd5});
        chk("t5_prd_after", 32'(prd_int_rat2ii), 32'd32);
        for (int i = 0; i < 15; i++) begin
            pair(1'b1, 5'd0, 5'd0, 5'(i + 1), 1'b1, 5'd0, 5'd0, 5'(i + 16));
            cyc();
        end
        pair(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 5'd0, 5'd0, 5'd2);
        #1 chk("t5_one_left_stall", 32'(stall_rat2id), 32'd1);
        pair(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 5'd0, 5'd0, 5'd0);
        #1 chk("t5_one_left_ok", 32'(stall_rat2id), 32'd0);
        cyc(); idle();
        chk("t5_last_tag", 32'(prd_int_rat2ii), 32'd63);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rat.md
RAT -- requirements
Module: rat

Interface
REQ-001 SHALL have parameter PTAGW, default 6, physical register tag width (2**PTAGW = 64 physical regs, 32 architectural).
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have res  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have valid_int_id2rat  input  1  int-slot instruction valid.
REQ-005 SHALL have rsrc_int_id2rat  input  10  int-slot {rs2,rs1} architectural sources.
REQ-006 SHALL have rd_int_id2rat  input  5  int-slot architectural destination.
REQ-007 SHALL have valid_ls_id2rat  input  1  ls-slot instruction valid.
REQ-008 SHALL have rsrc_ls_id2rat  input  10  ls-slot {rs2,rs1} architectural sources.
REQ-009 SHALL have rd_ls_id2rat  input  5  ls-slot architectural destination (0 for stores).
REQ-010 SHALL have stall_rat2id  output  1  pair not accepted this cycle; ID holds inputs.
REQ-011 SHALL have valid_rat2ii  output  1  renamed pair valid toward issuer.
REQ-012 SHALL have psrc_int_rat2ii  output  12  int-slot {prs2,prs1}.
REQ-013 SHALL have prd_int_rat2ii  output  6  int-slot newly allocated physical destination.
REQ-014 SHALL have psrc_ls_rat2ii  output  12  ls-slot {prs2,prs1}.
REQ-015 SHALL have prd_ls_rat2ii  output  6  ls-slot newly allocated physical destination.
REQ-016 SHALL have full_rob2rat  input  1  ROB cannot accept a pair.
REQ-017 SHALL have freeMeUp_int_rat2rob  output  6  previous mapping of int rd, freed at commit.
REQ-018 SHALL have freeMeUp_ls_rat2rob  output  6  previous mapping of ls rd, freed at commit.
REQ-019 SHALL have done_rat2rob  output  1  one-cycle pulse: freeMeUp outputs valid for the accepted pair.
REQ-020 SHALL have freeMeUp_0_rob2rat / freeMeUp_1_rob2rat  input  6 each  physical regs released by commit.
REQ-021 SHALL have valid_rob2rat  input  1  qualifies both commit-free inputs.

Function
REQ-022 SHALL keep a 32x6 map table and a 64-entry circular free-list FIFO with 7-bit count.
REQ-023 SHALL define need = (valid_int & rd_int!=0) + (valid_ls & rd_ls!=0); arch x0 is never renamed and maps to phys 0.
REQ-024 SHALL assert stall_rat2id combinationally when (valid_int|valid_ls) and (full_rob2rat or count < need).
REQ-025 SHALL accept a pair when (valid_int|valid_ls) and not stall; all *_rat2ii and *_rat2rob outputs update at the next edge (latency 1), done_rat2rob and valid_rat2ii high exactly one cycle per accept.
REQ-026 SHALL pop int allocation before ls allocation, in FIFO order; an invalid slot or rd=0 pops nothing, gives prd=0 and freeMeUp=0.
REQ-027 SHALL read sources from the map as it was before the accepted pair; ls-slot source equal to a renamed int rd SHALL use the new int prd (intra-pair bypass).
REQ-028 SHALL, when both slots rename the same rd, report int freeMeUp = old mapping, ls freeMeUp = int's new prd, final map = ls prd.
REQ-029 SHALL on valid_rob2rat push each nonzero freeMeUp_x_rob2rat (0 before 1); zero values are ignored.
REQ-030 SHALL allow push and pop in the same cycle: count_next = count + pushes - pops; pointers wrap modulo 64.
REQ-031 SHALL drive outputs valid_rat2ii=0, done_rat2rob=0 in cycles with no accept; other outputs hold.

Reset
REQ-032 SHALL on res: map[i]=i, free list = phys 32..63 in ascending order, count=32, all outputs 0.
REQ-033 SHALL let res override any same-cycle accept or commit-free; both are discarded.

Configuration
REQ-034 SHALL, with RAT_FREE_BYPASS_EN defined, compare need against count + same-cycle nonzero frees and let a freed tag be allocated in the cycle it arrives.
REQ-035 SHALL, without RAT_FREE_BYPASS_EN, compare against registered count only; frees are allocatable from the next cycle.

Verification
REQ-036 SHALL test: reset, int rd=5 ls rd=6 -> next cycle prd_int=32, prd_ls=33, freeMeUp 5/6, done=1.
REQ-037 SHALL test: int rd=3, ls rs1=3 rd=3 -> ls prs1=int prd=32, freeMeUp_int=3, freeMeUp_ls=32, map[3]=33.
REQ-038 SHALL test: 16 dual-rename pairs drain count to 0; 17th pair -> stall_rat2id=1, no done.
REQ-039 SHALL test: count=0, valid_rob2rat with frees 7,9 and pending pair -> with bypass allocates 7,9 same cycle; without, next cycle.
REQ-040 SHALL test: full_rob2rat=1 with count=32 -> stall, no pop; res mid-stream -> map identity, count=32.
